// File: rtl/pgu_seq_pkg.sv
// Shared constants and types for the PC generation unit.
package pgu_seq_pkg;

    // Default widths and boot address of the fetch PC.
    localparam int unsigned PGU_ADDR_SIZE = 32;
    localparam int unsigned PGU_IMM_SIZE  = 32;
    localparam logic [31:0] PGU_RESET_PC  = 32'h8000_0000;

    // Sequencer states. BOOT is left after one cycle; WAIT parks the unit
    // until EXU resolves an unpredicted JALR target.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // One-hot-ish RAS command. At most one of push/pop/replace is set.
    typedef struct packed {
        logic push;
        logic pop;
        logic replace;
    } ras_op_t;

endpackage

// File: rtl/pgu_seq_ras.sv
// Return-address stack: circular LIFO. A push onto a full stack overwrites
// the oldest entry. Replace rewrites the top entry, or pushes when empty.
module pgu_seq_ras
    import pgu_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ras_op_t           op,
    input  logic [ADDR_W-1:0] wr_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // ptr_q is the next free slot; the top entry lives one below it.
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);

    // Pointer/count update and write-port selection for the requested op.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (op.push || (op.replace && cnt_q == '0)) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (op.replace) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (op.pop && cnt_q != '0) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/pgu_seq.sv
// PC generation unit: holds the fetch PC, offers it to I-fetch with a
// valid/ready handshake and picks the next PC from flush, EXU JALR
// resolution, RAS prediction, decode jump target or sequential increment.
module pgu_seq
    import pgu_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = PGU_ADDR_SIZE,
    parameter int unsigned       IMM_W     = PGU_IMM_SIZE,
    parameter logic [ADDR_W-1:0] RESET_PC  = PGU_RESET_PC,
    parameter int unsigned       STEP      = 4,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              stall,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    input  logic              dec_valid,
    input  logic              dec_jump,
    input  logic [IMM_W-1:0]  dec_op1,
    input  logic [IMM_W-1:0]  dec_op2,
    input  logic              dec_jalr_rs1,
    input  logic              dec_is_call,
    input  logic              dec_is_ret,
    input  logic [ADDR_W-1:0] dec_link,
    input  logic              exu_jalr_valid,
    input  logic [ADDR_W-1:0] exu_jalr_pc,
    output logic              ras_hit
);

    // Handshake: pc is offered whenever pc_valid is high; fetch takes it on a
    // cycle with if_ready=1. The PC only advances (and decode is only acted
    // upon) when the offer is taken and the stall unit is not holding.

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ras_hit_q, ras_hit_d;

    logic              adv;
    logic              ras_upd;
    ras_op_t           ras_op;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ret_hit;
    logic [IMM_W-1:0]  jump_sum;
    logic [ADDR_W-1:0] jump_tgt;

    assign pc       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign ras_hit  = ras_hit_q;

    assign adv      = pc_valid & if_ready & ~stall;
    assign ret_hit  = dec_valid & dec_is_ret & ~ras_empty;

    // Jump target wraps modulo 2^ADDR_W; bit 0 cleared as for JALR.
    assign jump_sum = dec_op1 + dec_op2;
    assign jump_tgt = ADDR_W'($signed(jump_sum)) & {{(ADDR_W-1){1'b1}}, 1'b0};

    // RAS commands only from instructions actually consumed in RUN.
    assign ras_upd        = adv & dec_valid & (state_q == ST_RUN) & ~pipe_flush;
    assign ras_op.push    = ras_upd & dec_is_call & ~dec_is_ret;
    assign ras_op.pop     = ras_upd & dec_is_ret & ~dec_is_call;
    assign ras_op.replace = ras_upd & dec_is_call & dec_is_ret;

    pgu_seq_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (ras_op),
        .wr_data (dec_link),
        .top     (ras_top),
        .empty   (ras_empty)
    );

    // Next-PC selection and state transitions, in priority order.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ras_hit_d = ras_hit_q;
        if (pipe_flush) begin
            pc_d      = flush_pc;
            state_d   = ST_RUN;
            ras_hit_d = 1'b0;
        end else if (state_q == ST_WAIT && exu_jalr_valid) begin
            pc_d      = exu_jalr_pc;
            state_d   = ST_RUN;
            ras_hit_d = 1'b0;
        end else if (!adv) begin
            if (state_q == ST_BOOT) begin
                state_d = ST_RUN;
            end
        end else if (ret_hit) begin
            pc_d      = ras_top;
            ras_hit_d = 1'b1;
        end else if (dec_valid && dec_jump) begin
            pc_d      = jump_tgt;
            ras_hit_d = 1'b0;
        end else if (dec_valid && (dec_jalr_rs1 || dec_is_ret)) begin
            state_d = ST_WAIT;
        end else begin
            pc_d      = pc_q + ADDR_W'(STEP);
            ras_hit_d = 1'b0;
        end
    end

    // State, PC and RAS-hit flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            ras_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ras_hit_q <= ras_hit_d;
        end
    end

endmodule
